// File: rtl/pb_pkg.sv
// Shared constants and types for the pushbutton event path.
// Button count, event code width and default debounce length.
package pb_pkg;
  localparam int PB_COUNT = 21;
  localparam int PB_CODE_W = 5;
  localparam int PB_DEBOUNCE_DEFAULT = 3;
  typedef logic [PB_CODE_W-1:0] pb_code_t;
endpackage

// File: rtl/pb_debounce.sv
// One button: 2-FF synchronizer, counter debounce, press pulse.
// press is high in the cycle held is about to rise.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic pb,
  output logic held,
  output logic press
);
  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          last;

  assign last  = (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press = !held && s && last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      sync1 <= pb;
      s     <= sync1;
      if (s == held) begin
        cnt <= '0;
      end else if (last) begin
        held <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pb_event_encoder.sv
// Debounced pushbuttons to an encoded press-event stream.
// Pending mask feeds a lowest-index encoder into a small FIFO.
module pb_event_encoder
  import pb_pkg::*;
#(
  parameter int NUM_PB = PB_COUNT,
  parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(NUM_PB)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] held,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CW-1:0]     evt_code,
  output logic              overflow,
  input  logic              overflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_PB-1:0] press;
  logic [NUM_PB-1:0] pending;
  logic [NUM_PB-1:0] clr_mask;
  logic [CW-1:0]     sel;
  logic [CW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              push;
  logic              pop;
  logic              ovf_set;

  for (genvar i = 0; i < NUM_PB; i++) begin : g_db
    pb_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .pb   (pb[i]),
      .held (held[i]),
      .press(press[i])
    );
  end

  // Descending scan so the lowest set index is the one left in sel.
  always_comb begin
    sel = '0;
    for (int i = NUM_PB - 1; i >= 0; i--) begin
      if (pending[i]) sel = CW'(i);
    end
  end

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign evt_code  = mem[rd_ptr];
  assign push      = (|pending) && !full;
  assign pop       = evt_valid && evt_ready;
  assign clr_mask  = push ? (NUM_PB'(1) << sel) : '0;
  assign ovf_set   = |(press & pending & ~clr_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | press;
      if (ovf_set) overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= sel;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_pb_event_encoder.sv
// Directed self-checking bench for pb_event_encoder.
// Table of single presses plus hand-written multi-cycle sequences.
module tb_pb_event_encoder;
  import pb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] pb = '0;
  logic [20:0] held;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [4:0]  evt_code;
  logic        overflow;
  logic        overflow_clr = 1'b0;

  int total = 0;
  int bad = 0;
  int got[$];

  typedef struct {
    int       idx;
    pb_code_t code;
  } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  pb_event_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .pb          (pb),
    .held        (held),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  // Inputs change only #1 after posedge, so negedge values hold at the next edge.
  always @(negedge clk)
    if (!reset && evt_valid && evt_ready) got.push_back(int'(evt_code));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic chk_q(input string n, input int exp[$]);
    chk({n, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", n, i), got[i], exp[i]);
  endtask

  initial begin
    tbl[0] = '{idx: 0,  code: 5'd0};
    tbl[1] = '{idx: 7,  code: 5'd7};
    tbl[2] = '{idx: 13, code: 5'd13};
    tbl[3] = '{idx: 20, code: 5'd20};

    step(2);
    chk("rst_held", int'(held), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_code", int'(evt_code), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset = 1'b0;
    step(2);

    // Single press: latency edges counted from the first stable edge.
    evt_ready = 1'b1;
    pb = 21'(1) << 7;
    step(4);
    chk("sp_held_e3", int'(held[7]), 0);
    step(1);
    chk("sp_held_e4", int'(held[7]), 1);
    chk("sp_valid_e4", int'(evt_valid), 0);
    step(1);
    chk("sp_valid_e5", int'(evt_valid), 1);
    chk("sp_code_e5", int'(evt_code), 7);
    step(1);
    chk("sp_valid_e6", int'(evt_valid), 0);
    pb = '0;
    step(10);
    chk("sp_rel_held", int'(held[7]), 0);
    chk_q("sp_events", '{7});

    foreach (tbl[t]) begin
      got.delete();
      pb = 21'(1) << tbl[t].idx;
      step(5);
      chk($sformatf("tbl%0d_early", t), int'(evt_valid), 0);
      step(1);
      chk($sformatf("tbl%0d_valid", t), int'(evt_valid), 1);
      chk($sformatf("tbl%0d_code", t), int'(evt_code), int'(tbl[t].code));
      pb = '0;
      step(10);
      chk($sformatf("tbl%0d_n", t), got.size(), 1);
    end

    // Bounce rejection.
    got.delete();
    pb[2] = 1'b1; step(2);
    pb[2] = 1'b0; step(2);
    pb[2] = 1'b1; step(1);
    pb[2] = 1'b0; step(10);
    chk("bn_held", int'(held[2]), 0);
    chk("bn_none", got.size(), 0);
    pb[2] = 1'b1; step(12);
    chk_q("bn_hold", '{2});
    pb = '0; step(10);

    // Simultaneous presses.
    got.delete();
    pb = (21'(1) << 17) | (21'(1) << 3);
    step(6);
    chk("sim_code_a", int'(evt_code), 3);
    step(1);
    chk("sim_valid_b", int'(evt_valid), 1);
    chk("sim_code_b", int'(evt_code), 17);
    step(4);
    chk_q("sim_events", '{3, 17});
    pb = '0; step(10);

    // Backpressure.
    got.delete();
    evt_ready = 1'b0;
    pb = 21'h010117;
    step(14);
    chk("bp_held", int'(held), 32'h010117);
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_head", int'(evt_code), 0);
    evt_ready = 1'b1;
    step(16);
    chk_q("bp_events", '{0, 1, 2, 4, 8, 16});
    chk("bp_ovf", int'(overflow), 0);
    pb = '0; step(10);

    // Overflow: a second press of a still-pending button.
    got.delete();
    evt_ready = 1'b0;
    pb = 21'h00000f; step(12);
    pb = 21'(1) << 5; step(8);
    chk("ov_ovf_first", int'(overflow), 0);
    pb = '0; step(8);
    pb = 21'(1) << 5; step(8);
    chk("ov_ovf_set", int'(overflow), 1);
    pb = '0;
    evt_ready = 1'b1;
    step(12);
    chk_q("ov_events", '{0, 1, 2, 3, 5});
    chk("ov_sticky", int'(overflow), 1);
    overflow_clr = 1'b1; step(1);
    overflow_clr = 1'b0;
    chk("ov_clr", int'(overflow), 0);

    // Reset mid-operation with events queued and a button held.
    got.delete();
    evt_ready = 1'b0;
    pb = 21'h000007; step(12);
    pb = 21'h000207; step(3);
    reset = 1'b1; #1;
    chk("rm_valid", int'(evt_valid), 0);
    chk("rm_code", int'(evt_code), 0);
    chk("rm_held", int'(held), 0);
    chk("rm_ovf", int'(overflow), 0);
    pb = 21'(1) << 9;
    step(2);
    reset = 1'b0;
    step(5);
    chk("rm_early", int'(evt_valid), 0);
    step(1);
    chk("rm_valid9", int'(evt_valid), 1);
    chk("rm_code9", int'(evt_code), 9);
    evt_ready = 1'b1;
    step(10);
    chk_q("rm_events", '{9});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
